// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs_pkg
//  Description : Shared opcodes, branch encodings, NOP and fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam logic [6:0] c_opc_branch = 7'b110_0011;
    localparam logic [6:0] c_opc_jal    = 7'b110_1111;
    localparam logic [6:0] c_opc_jalr   = 7'b110_0111;

    localparam logic [2:0] c_bt_beq  = 3'b000;
    localparam logic [2:0] c_bt_bne  = 3'b001;
    localparam logic [2:0] c_bt_blt  = 3'b100;
    localparam logic [2:0] c_bt_bge  = 3'b101;
    localparam logic [2:0] c_bt_bltu = 3'b110;
    localparam logic [2:0] c_bt_bgeu = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] c_nop_inst = 32'h0000_0013;

    localparam logic [1:0] c_st_boot   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp
//  Description : Evaluates a conditional-branch predicate from funct3.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp
    import cpu_defs_pkg::*;
(
    input  logic [2:0]  BranchType,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (BranchType)
            c_bt_beq:  taken = (rs1_val == rs2_val);
            c_bt_bne:  taken = (rs1_val != rs2_val);
            c_bt_blt:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            c_bt_bge:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            c_bt_bltu: taken = (rs1_val <  rs2_val);
            c_bt_bgeu: taken = (rs1_val >= rs2_val);
            default:   taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Single-cycle fetch stage with zero-bubble branch/jump redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               halt,
    input  logic               Branch,
    input  logic [2:0]         BranchType,
    input  logic               Jump,
    input  logic               is_jalr,
    input  logic [31:0]        rs1_val,
    input  logic [31:0]        rs2_val,
    input  logic [31:0]        imm,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic               fault
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_fault;

    logic        w_cond;
    logic        w_redirect;
    logic        w_misaligned;
    logic        w_advance;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_next_pc;

    branch_cmp u_branch_cmp (
        .BranchType (BranchType),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .taken      (w_cond)
    );

    assign w_redirect = Jump | (Branch & w_cond);
    assign w_jalr_sum = rs1_val + imm;

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (Jump & is_jalr)
            w_next_pc = w_jalr_sum & ~32'h1;
        else if (w_redirect)
            w_next_pc = r_pc + imm;
    end

    assign w_misaligned = w_redirect & (w_next_pc[1:0] != 2'b00);
    assign w_advance    = (r_state == c_st_run) & ~halt & ~stall;

    // ROM is addressed with the upcoming pc so its data lines up with pc next cycle
    always_comb begin
        if (!rst_n || r_state == c_st_boot)
            imem_addr = RESET_PC[IMEM_AW+1:2];
        else if (w_advance)
            imem_addr = w_next_pc[IMEM_AW+1:2];
        else
            imem_addr = r_pc[IMEM_AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_boot;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                c_st_boot: begin
                    r_state <= c_st_run;
                    r_pc    <= RESET_PC;
                end
                c_st_run: begin
                    if (halt) begin
                        r_state <= c_st_halted;
                    end else if (!stall) begin
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= c_st_halted;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                c_st_halted: r_state <= c_st_halted;
                default:     r_state <= c_st_halted;
            endcase
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = r_pc + 32'd4;
    assign fault      = r_fault;
    assign inst_valid = rst_n & (r_state == c_st_run);
    assign inst       = inst_valid ? imem_rdata : c_nop_inst;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter IMEM_AW, default 14, instruction-memory word-address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port stall, input, 1, hold current instruction (downstream I/O wait).
REQ-006 SHALL have port halt, input, 1, request to stop fetching permanently until reset.
REQ-007 SHALL have port Branch, input, 1, current instruction is a conditional branch.
REQ-008 SHALL have port BranchType, input, 3, funct3 of the branch: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
REQ-009 SHALL have port Jump, input, 1, current instruction is JAL or JALR.
REQ-010 SHALL have port is_jalr, input, 1, qualifies Jump as JALR.
REQ-011 SHALL have port rs1_val, input, 32, register operand 1.
REQ-012 SHALL have port rs2_val, input, 32, register operand 2.
REQ-013 SHALL have port imm, input, 32, sign-extended immediate of current instruction.
REQ-014 SHALL have port imem_addr, output, IMEM_AW, synchronous-read ROM word address.
REQ-015 SHALL have port imem_rdata, input, 32, ROM data, valid one cycle after imem_addr.
REQ-016 SHALL have port pc, output, 32, address of the instruction on inst.
REQ-017 SHALL have port pc_plus4, output, 32, pc + 4 (link value).
REQ-018 SHALL have port inst, output, 32, current instruction to the decoder.
REQ-019 SHALL have port inst_valid, output, 1, inst/pc hold a real instruction.
REQ-020 SHALL have port fault, output, 1, sticky misaligned-target flag.

Function
REQ-021 SHALL implement FSM states BOOT, RUN, HALTED.
REQ-022 BOOT SHALL last exactly one cycle after reset release, drive imem_addr = RESET_PC[IMEM_AW+1:2], then go to RUN with pc = RESET_PC and inst_valid = 1.
REQ-023 In RUN, taken = Branch & cond(BranchType, rs1_val, rs2_val); signed compare for blt/bge, unsigned for bltu/bgeu; BranchType 010/011 SHALL be not-taken.
REQ-024 Target SHALL be (rs1_val + imm) & ~32'h1 when Jump & is_jalr, pc + imm when Jump & !is_jalr or taken, else pc + 4; all additions modulo 2^32.
REQ-025 When not stalled, imem_addr SHALL equal next_pc[IMEM_AW+1:2] combinationally and pc SHALL load next_pc on the edge, giving zero-bubble redirects.
REQ-026 When stall = 1, pc and inst SHALL hold and imem_addr SHALL equal pc[IMEM_AW+1:2]; branch/jump inputs SHALL be ignored.
REQ-027 inst SHALL be imem_rdata in RUN; pc values beyond the ROM SHALL wrap modulo 2^IMEM_AW words.
REQ-028 A non-stalled redirect with next_pc[1:0] != 0 SHALL set fault, leave pc unchanged, and go to HALTED.
REQ-029 halt = 1 in RUN SHALL move to HALTED at the next edge; halt takes priority over stall and redirect in the same cycle.
REQ-030 In HALTED, inst_valid SHALL be 0, inst SHALL be 32'h0000_0013 (nop), pc SHALL hold; only reset exits.

Reset
REQ-031 rst_n = 0 at an edge SHALL force state BOOT, pc = RESET_PC, inst_valid = 0, fault = 0, regardless of stall/halt, including mid-redirect.
REQ-032 During reset, inst SHALL read 32'h0000_0013 and imem_addr SHALL equal RESET_PC[IMEM_AW+1:2].

Structure
REQ-033 Opcode constants, BranchType encodings, NOP value and FSM state encoding SHALL live in shared package cpu_defs_pkg.
REQ-034 Branch-condition evaluation SHALL be a sub-module branch_cmp (BranchType, rs1_val, rs2_val -> taken).

Verification
REQ-035 Reset release, stall = 0, no branches -> pc = 0, 4, 8 on consecutive cycles; inst_valid = 1 from the second cycle after release.
REQ-036 At pc = 0x10: Branch = 1, BranchType = 100, rs1_val = -1, rs2_val = 1, imm = -8 -> next pc = 0x08; the same with BranchType = 110 -> next pc = 0x14.
REQ-037 JALR with rs1_val = 0x101, imm = 0x20 -> next pc = 0x120, fault = 0; JAL with imm = 0x6 -> fault = 1, HALTED, pc holds.
REQ-038 stall = 1 for 3 cycles during a taken beq -> pc/inst unchanged for 3 cycles, then redirect applied on the first non-stalled cycle.
REQ-039 halt and stall asserted together -> HALTED next cycle, inst_valid = 0, inst = 0x00000013; rst_n = 0 -> BOOT, pc = RESET_PC.
